icache_dm: RTL and testbench
============================

// Module: icache_dm
// PURPOSE
//  Direct-mapped, read-only instruction cache between the fetch stage and main_mem.
//  Serves 32-bit instruction reads from CACHE_LINE_WIDTH-bit lines.
//  On a miss, fetches one whole line through main_mem's read port (line request in, line plus done pulse back).
//  No write path; software coherence is via i_flush.
// PARAMETERS
//  ADDR_WIDTH        64   byte-address width, CPU side and memory side
//  INSTR_WIDTH       32   width of the word returned to fetch
//  CACHE_LINE_WIDTH  256  line width; matches main_mem o_cache_line (32 B/line)
//  NUM_LINES         64   number of lines, power of 2; INDEX_W = log2(NUM_LINES)
//  Derived: OFFSET_W = 5, TAG_W = ADDR_WIDTH - OFFSET_W - INDEX_W
// PORTS
//  i_clk               in   1    clock, all logic on the rising edge
//  i_rst               in   1    synchronous reset, active-high
//  i_cpu_req           in   1    fetch request; sampled only while o_cpu_ready = 1
//  i_cpu_addr          in   ADDR_WIDTH        fetch byte address; bits [1:0] ignored
//  o_cpu_ready         out  1    cache can accept a request (state IDLE)
//  o_cpu_valid         out  1    one-cycle pulse: o_cpu_instr is valid
//  o_cpu_instr         out  INSTR_WIDTH       instruction word
//  i_flush             in   1    invalidate all lines
//  o_mem_read_req      out  1    one-cycle line-fetch pulse to main_mem
//  o_mem_read_address  out  ADDR_WIDTH        line address, bits [4:0] = 0
//  i_mem_read_done     in   1    main_mem line-valid pulse
//  i_cache_line        in   CACHE_LINE_WIDTH  returned line; word k at bits [32k+31:32k]
// BEHAVIOUR
//  Storage: data[NUM_LINES], tag[NUM_LINES], valid[NUM_LINES].
//    Fields: index = addr[OFFSET_W+INDEX_W-1:OFFSET_W], word = addr[4:2].
//  Reset: valid[] all cleared; state -> IDLE; flush-pending cleared.
//    Outputs: o_cpu_valid = 0, o_cpu_instr = 0, o_mem_read_req = 0, o_mem_read_address = 0.
//    o_cpu_ready = 1 from the first cycle after reset deasserts.
//  FSM states: IDLE, LOOKUP, REFILL_REQ, REFILL_WAIT, RESPOND.
//  IDLE:
//    o_cpu_ready = 1.
//    i_flush = 1 clears all valid[] this cycle, and any request in the same cycle is ignored (flush wins).
//    Otherwise i_cpu_req = 1 latches the address -> LOOKUP.
//  LOOKUP:
//    Hit (valid[idx] && tag[idx] == addr tag): o_cpu_instr = data[idx] word; o_cpu_valid = 1 next cycle; -> IDLE.
//    Hit latency is 2 cycles from request to valid; throughput is one request per 2 cycles.
//    Miss: -> REFILL_REQ.
//  REFILL_REQ:
//    Drive o_mem_read_req = 1 for exactly one cycle.
//    o_mem_read_address = {addr[ADDR_WIDTH-1:5], 5'b0}.
//    -> REFILL_WAIT.
//  REFILL_WAIT:
//    o_mem_read_address is held; o_mem_read_req = 0; wait indefinitely.
//    On i_mem_read_done: write data[idx] = i_cache_line, tag[idx] = addr tag, valid[idx] = 1 -> RESPOND.
//  RESPOND:
//    o_cpu_instr = the requested word, taken directly from the captured line.
//    o_cpu_valid = 1 for one cycle -> IDLE.
//    Miss latency with main_mem's one-cycle read is 5 cycles from request to valid.
//  o_cpu_valid is never asserted for two consecutive cycles.
//    o_cpu_instr holds its last value when o_cpu_valid = 0.
//  i_flush outside IDLE is latched as flush-pending.
//    The in-flight miss still completes and is responded to.
//    All valid[] are cleared on the next IDLE cycle; o_cpu_ready = 0 in that cycle.
//  i_mem_read_done outside REFILL_WAIT is ignored. This covers a stale done after reset mid-refill.
//  Conflict miss: the new line overwrites the line at the same index; no victim handling.
//  i_cpu_req while o_cpu_ready = 0 is dropped; the requester holds the request until ready.
// TESTING
//  1. Reset, request 0x1008 (cold miss).
//     Required: one o_mem_read_req pulse with address 0x1000; line from main_mem returned.
//     Required: o_cpu_valid 5 cycles after the request, o_cpu_instr = bits [95:64] of the line.
//  2. Repeat 0x1008, then 0x101C.
//     Required: o_mem_read_req never asserts; valid 2 cycles after each request.
//     Required: 0x101C returns bits [255:224] of the line.
//  3. With NUM_LINES = 64, request 0x1000, then 0x1800 (same index), then 0x1000.
//     Required: three line fetches, to 0x1000, 0x1800 and 0x1000, with correct data each time.
//  4. Assert i_flush in REFILL_WAIT for 0x2000.
//     Required: the miss completes with valid data; o_cpu_ready = 0 for one IDLE cycle.
//     Required: the next 0x2000 request misses and re-fetches.
//  5. Assert i_rst in REFILL_WAIT, then pulse i_mem_read_done.
//     Required: o_cpu_valid stays 0 and no line is written; a later 0x1008 request misses.
//  6. Hold i_cpu_req = 1 continuously across 4 hitting addresses.
//     Required: exactly 4 o_cpu_valid pulses, spaced 2 cycles apart; none back-to-back.

Source files
------------

// File: rtl/icache_dm.sv
// icache_dm: direct-mapped read-only instruction cache with whole-line refill from main_mem
module icache_dm #(
    parameter int ADDR_WIDTH       = 64,
    parameter int INSTR_WIDTH      = 32,
    parameter int CACHE_LINE_WIDTH = 256,
    parameter int NUM_LINES        = 64
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_cpu_req,
    input  logic [ADDR_WIDTH-1:0]       i_cpu_addr,
    output logic                        o_cpu_ready,
    output logic                        o_cpu_valid,
    output logic [INSTR_WIDTH-1:0]      o_cpu_instr,
    input  logic                        i_flush,
    output logic                        o_mem_read_req,
    output logic [ADDR_WIDTH-1:0]       o_mem_read_address,
    input  logic                        i_mem_read_done,
    input  logic [CACHE_LINE_WIDTH-1:0] i_cache_line
);
    localparam int OFFSET_W = $clog2(CACHE_LINE_WIDTH / 8);
    localparam int INDEX_W  = $clog2(NUM_LINES);
    localparam int TAG_W    = ADDR_WIDTH - OFFSET_W - INDEX_W;
    localparam int WORD_W   = OFFSET_W - $clog2(INSTR_WIDTH / 8);
    typedef enum logic [2:0] {IDLE, LOOKUP, REFILL_REQ, REFILL_WAIT, RESPOND} state_t;
    state_t                      state, state_n;
    logic [ADDR_WIDTH-1:0]       addr_q;
    logic [CACHE_LINE_WIDTH-1:0] data [NUM_LINES];
    logic [TAG_W-1:0]            tags [NUM_LINES];
    logic [NUM_LINES-1:0]        valid;
    logic [CACHE_LINE_WIDTH-1:0] line_q;
    logic                        flush_pend;
    logic [INDEX_W-1:0]          idx;
    logic [TAG_W-1:0]            tag;
    logic [WORD_W-1:0]           word;
    logic                        hit, accept, fill, respond_n, unused_ok;
    logic [CACHE_LINE_WIDTH-1:0] resp_line;
    assign idx            = addr_q[OFFSET_W+INDEX_W-1:OFFSET_W];
    assign tag            = addr_q[ADDR_WIDTH-1 -: TAG_W];
    assign word           = addr_q[OFFSET_W-1 -: WORD_W];
    assign unused_ok      = ^addr_q[OFFSET_W-WORD_W-1:0];
    assign hit            = valid[idx] && tags[idx] == tag;
    assign o_cpu_ready    = state == IDLE && !flush_pend;
    assign accept         = o_cpu_ready && !i_flush && i_cpu_req;
    assign fill           = state == REFILL_WAIT && i_mem_read_done;
    assign respond_n      = (state == LOOKUP && hit) || state == RESPOND;
    assign o_mem_read_req = state == REFILL_REQ;
    assign resp_line      = state == RESPOND ? line_q : data[idx];
    always_comb begin
        state_n = state;
        case (state)
            IDLE:        state_n = accept ? LOOKUP : IDLE;
            LOOKUP:      state_n = hit ? IDLE : REFILL_REQ;
            REFILL_REQ:  state_n = REFILL_WAIT;
            REFILL_WAIT: state_n = i_mem_read_done ? RESPOND : REFILL_WAIT;
            RESPOND:     state_n = IDLE;
            default:     state_n = IDLE;
        endcase
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state              <= IDLE;
            valid              <= '0;
            flush_pend         <= 1'b0;
            addr_q             <= '0;
            o_cpu_valid        <= 1'b0;
            o_cpu_instr        <= '0;
            o_mem_read_address <= '0;
        end else begin
            state       <= state_n;
            o_cpu_valid <= respond_n;
            if (respond_n)
                o_cpu_instr <= resp_line[INSTR_WIDTH*32'(word) +: INSTR_WIDTH];
            if (accept)
                addr_q <= i_cpu_addr;
            if (state == LOOKUP && !hit)
                o_mem_read_address <= {addr_q[ADDR_WIDTH-1:OFFSET_W], {OFFSET_W{1'b0}}};
            // A flush seen mid-miss is deferred to the next IDLE cycle
            flush_pend <= state == IDLE ? 1'b0 : (flush_pend | i_flush);
            if (state == IDLE && (flush_pend || i_flush))
                valid <= '0;
            else if (fill)
                valid[idx] <= 1'b1;
        end
    end
    always_ff @(posedge i_clk) begin
        if (fill && !i_rst) begin
            data[idx] <= i_cache_line;
            tags[idx] <= tag;
            line_q    <= i_cache_line;
        end
    end
endmodule

// File: tb/tb_icache_dm.sv
// tb_icache_dm: directed checks of icache_dm against a latency-programmable main_mem model
module tb_icache_dm;
    logic         clk = 1'b0, rst = 1'b1, cpu_req = 1'b0, flush = 1'b0, mem_force = 1'b0;
    logic [63:0]  cpu_addr = '0;
    logic         cpu_ready, cpu_valid, mem_req, mem_done;
    logic [31:0]  cpu_instr;
    logic [63:0]  mem_addr;
    logic [255:0] mem_line;
    logic [63:0]  pend_addr = '0;
    logic [63:0]  fetch_log [64];
    logic         prev_v = 1'b0;
    int tests = 0, fails = 0, fetches = 0, vcount = 0, b2b = 0, mem_lat = 1, cnt = 0;

    icache_dm dut (
        .i_clk(clk), .i_rst(rst), .i_cpu_req(cpu_req), .i_cpu_addr(cpu_addr),
        .o_cpu_ready(cpu_ready), .o_cpu_valid(cpu_valid), .o_cpu_instr(cpu_instr),
        .i_flush(flush), .o_mem_read_req(mem_req), .o_mem_read_address(mem_addr),
        .i_mem_read_done(mem_done), .i_cache_line(mem_line)
    );

    always #5 clk = ~clk;

    // Word k of the line at address a is 0xC0DE0000 ^ (a + k)
    function automatic logic [255:0] make_line(input logic [63:0] a);
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[32*k +: 32] = 32'hC0DE0000 ^ (a[31:0] + 32'(k));
        return r;
    endfunction

    assign mem_done = cnt == 1 || mem_force;
    assign mem_line = make_line(pend_addr);

    always @(posedge clk) begin
        if (mem_req) begin
            pend_addr <= mem_addr;
            cnt <= mem_lat;
            fetch_log[fetches % 64] <= mem_addr;
            fetches <= fetches + 1;
        end else if (cnt != 0) cnt <= cnt - 1;
    end

    always @(negedge clk) begin
        if (cpu_valid) vcount <= vcount + 1;
        if (cpu_valid && prev_v) b2b <= b2b + 1;
        prev_v <= cpu_valid;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [63:0] a, output int lat, output logic [31:0] instr);
        int n = 0;
        while (!cpu_ready && n < 20) begin tick(); n++; end
        cpu_req = 1'b1; cpu_addr = a;
        tick();
        cpu_req = 1'b0; lat = 1;
        while (!cpu_valid && lat < 30) begin tick(); lat++; end
        instr = cpu_instr;
    endtask

    task automatic test_reset();
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        tests++; if (cpu_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", cpu_ready); end
        tests++; if (cpu_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", cpu_valid); end
        tests++; if (cpu_instr !== 32'h0) begin fails++; $display("FAIL reset_instr: got %h want 0", cpu_instr); end
        tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
        tests++; if (mem_addr !== 64'h0) begin fails++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    endtask

    task automatic test_cold_miss();
        int f0 = fetches, lat;
        logic [31:0] ins;
        fetch(64'h1008, lat, ins);
        tests++; if (lat !== 5) begin fails++; $display("FAIL cold_latency: got %0d want 5", lat); end
        tests++; if (ins !== 32'hC0DE1002) begin fails++; $display("FAIL cold_instr: got %h want C0DE1002", ins); end
        tests++; if (fetches - f0 !== 1) begin fails++; $display("FAIL cold_fetch_count: got %0d want 1", fetches - f0); end
        tests++; if (fetch_log[f0 % 64] !== 64'h1000) begin fails++; $display("FAIL cold_fetch_addr: got %h want 1000", fetch_log[f0 % 64]); end
    endtask

    task automatic test_hits();
        int f0 = fetches, lat;
        logic [31:0] ins;
        fetch(64'h1008, lat, ins);
        tests++; if (lat !== 2) begin fails++; $display("FAIL hit0_latency: got %0d want 2", lat); end
        tests++; if (ins !== 32'hC0DE1002) begin fails++; $display("FAIL hit0_instr: got %h want C0DE1002", ins); end
        fetch(64'h101C, lat, ins);
        tests++; if (lat !== 2) begin fails++; $display("FAIL hit1_latency: got %0d want 2", lat); end
        tests++; if (ins !== 32'hC0DE1007) begin fails++; $display("FAIL hit1_instr: got %h want C0DE1007", ins); end
        tests++; if (fetches - f0 !== 0) begin fails++; $display("FAIL hit_fetch_count: got %0d want 0", fetches - f0); end
    endtask

    task automatic test_conflict();
        int f0, lat;
        logic [31:0] ins;
        logic [63:0] addrs [3];
        logic [31:0] exp [3];
        addrs = '{64'h1000, 64'h1800, 64'h1000};
        exp = '{32'hC0DE1000, 32'hC0DE1800, 32'hC0DE1000};
        flush = 1'b1; cpu_req = 1'b1; cpu_addr = 64'h1000;
        tick();
        flush = 1'b0; cpu_req = 1'b0;
        tests++; if (cpu_ready !== 1'b1) begin fails++; $display("FAIL flush_wins_ready: got %b want 1", cpu_ready); end
        f0 = fetches;
        for (int i = 0; i < 3; i++) begin
            fetch(addrs[i], lat, ins);
            tests++; if (lat !== 5) begin fails++; $display("FAIL conflict%0d_latency: got %0d want 5", i, lat); end
            tests++; if (ins !== exp[i]) begin fails++; $display("FAIL conflict%0d_instr: got %h want %h", i, ins, exp[i]); end
            tests++; if (fetch_log[(f0 + i) % 64] !== addrs[i]) begin fails++; $display("FAIL conflict%0d_addr: got %h want %h", i, fetch_log[(f0 + i) % 64], addrs[i]); end
        end
        tests++; if (fetches - f0 !== 3) begin fails++; $display("FAIL conflict_fetch_count: got %0d want 3", fetches - f0); end
    endtask

    task automatic test_flush_refill();
        int f0 = fetches, n = 0, lat;
        logic [31:0] ins;
        mem_lat = 4;
        cpu_req = 1'b1; cpu_addr = 64'h2000;
        tick();
        cpu_req = 1'b0;
        tick(); tick();
        flush = 1'b1; tick(); flush = 1'b0;
        while (!cpu_valid && n < 20) begin tick(); n++; end
        tests++; if (cpu_valid !== 1'b1) begin fails++; $display("FAIL flush_miss_valid: got %b want 1", cpu_valid); end
        tests++; if (cpu_instr !== 32'hC0DE2000) begin fails++; $display("FAIL flush_miss_instr: got %h want C0DE2000", cpu_instr); end
        tests++; if (cpu_ready !== 1'b0) begin fails++; $display("FAIL flush_idle_ready: got %b want 0", cpu_ready); end
        tick();
        tests++; if (cpu_ready !== 1'b1) begin fails++; $display("FAIL flush_after_ready: got %b want 1", cpu_ready); end
        mem_lat = 1;
        fetch(64'h2000, lat, ins);
        tests++; if (lat !== 5) begin fails++; $display("FAIL flush_refetch_latency: got %0d want 5", lat); end
        tests++; if (ins !== 32'hC0DE2000) begin fails++; $display("FAIL flush_refetch_instr: got %h want C0DE2000", ins); end
        tests++; if (fetches - f0 !== 2) begin fails++; $display("FAIL flush_fetch_count: got %0d want 2", fetches - f0); end
    endtask

    task automatic test_reset_refill();
        int v0, lat;
        logic [31:0] ins;
        mem_lat = 0;
        cpu_req = 1'b1; cpu_addr = 64'h1008;
        tick();
        cpu_req = 1'b0;
        tick(); tick();
        rst = 1'b1; tick(); rst = 1'b0;
        tests++; if (cpu_ready !== 1'b1) begin fails++; $display("FAIL rst_refill_ready: got %b want 1", cpu_ready); end
        v0 = vcount;
        mem_force = 1'b1; tick(); mem_force = 1'b0;
        tick(); tick(); tick();
        tests++; if (vcount - v0 !== 0) begin fails++; $display("FAIL rst_stale_done_valid: got %0d pulses want 0", vcount - v0); end
        mem_lat = 1;
        fetch(64'h1008, lat, ins);
        tests++; if (lat !== 5) begin fails++; $display("FAIL rst_refetch_latency: got %0d want 5", lat); end
        tests++; if (ins !== 32'hC0DE1002) begin fails++; $display("FAIL rst_refetch_instr: got %h want C0DE1002", ins); end
    endtask

    task automatic test_back_to_back();
        int f0 = fetches, v0, n = 0;
        logic [63:0] addrs [4];
        logic [31:0] exp [4];
        addrs = '{64'h1000, 64'h1004, 64'h1008, 64'h100C};
        exp = '{32'hC0DE1000, 32'hC0DE1001, 32'hC0DE1002, 32'hC0DE1003};
        while (!cpu_ready && n < 20) begin tick(); n++; end
        tick();
        v0 = vcount;
        cpu_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cpu_addr = addrs[i];
            tick();
            tests++; if (cpu_valid !== 1'b0) begin fails++; $display("FAIL b2b%0d_gap: got %b want 0", i, cpu_valid); end
            tick();
            if (i == 3) cpu_req = 1'b0;
            tests++; if (cpu_valid !== 1'b1 || cpu_instr !== exp[i]) begin fails++; $display("FAIL b2b%0d_resp: got valid=%b instr=%h want 1/%h", i, cpu_valid, cpu_instr, exp[i]); end
        end
        tick(); tick(); tick();
        tests++; if (vcount - v0 !== 4) begin fails++; $display("FAIL b2b_pulses: got %0d want 4", vcount - v0); end
        tests++; if (fetches - f0 !== 0) begin fails++; $display("FAIL b2b_fetch_count: got %0d want 0", fetches - f0); end
        tests++; if (b2b !== 0) begin fails++; $display("FAIL valid_back_to_back: got %0d want 0", b2b); end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hits();
        test_conflict();
        test_flush_refill();
        test_reset_refill();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
